// File: rtl/mbist_mem_router.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mbist_mem_router: routes MBIST accesses to NUM_MEM memories, returns tagged  |
// | read data and drains in-flight reads on select change. Option: MBIST_BROADCAST_EN |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module mbist_mem_router #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_MEM    = 4,
  parameter int SEL_WIDTH  = 3,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
`ifdef MBIST_BROADCAST_EN
  input  logic                             broadcast_mbist,
  output logic                             miscompare_mbist,
`endif
  input  logic [SEL_WIDTH-1:0]             memory_sel,
  input  logic                             req_mbist,
  input  logic                             write_read_mbist,
  input  logic [ADDR_WIDTH-1:0]            address_mbist,
  input  logic [DATA_WIDTH-1:0]            wdata_mbist,
  output logic                             ready_mbist,
  output logic [DATA_WIDTH-1:0]            rdata_mbist,
  output logic                             rvalid_mbist,
  output logic                             sel_err,
  output logic [NUM_MEM-1:0]               req_mem,
  output logic [NUM_MEM-1:0]               write_read_mem,
  output logic [NUM_MEM*ADDR_WIDTH-1:0]    address_mem,
  output logic [NUM_MEM*DATA_WIDTH-1:0]    wdata_mem,
  input  logic [NUM_MEM*DATA_WIDTH-1:0]    rdata_mem
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam int CNT_W = $clog2(RD_LATENCY + 3);
  localparam logic [SEL_WIDTH:0] NUM_MEM_C = (SEL_WIDTH+1)'(NUM_MEM);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic                             bcast;
  logic [1:0]                       state_q, state_d;
  logic [SEL_WIDTH-1:0]             cur_sel_q, cur_sel_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [DEPTH-1:0]                 tag_vld_q, tag_vld_d;
  logic [DEPTH-1:0][SEL_WIDTH-1:0]  tag_sel_q, tag_sel_d;
  logic [NUM_MEM-1:0]               req_q, req_d, wr_q, wr_d;
  logic [NUM_MEM*ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [NUM_MEM*DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]            rdata_q, rdata_d;
  logic                             rvalid_q, rvalid_d;
  logic                             sel_err_q, sel_err_d;
  logic                             sel_ok, sel_hit, accept, rd_push, ret;

`ifdef MBIST_BROADCAST_EN
  assign bcast = broadcast_mbist;
`else
  assign bcast = 1'b0;
`endif

  assign sel_ok  = {1'b0, memory_sel} < NUM_MEM_C;
  assign sel_hit = (memory_sel == cur_sel_q);
  assign accept  = req_mbist & ready_mbist;
  // Out-of-range reads are consumed without a strobe, so nothing comes back to track.
  assign rd_push = accept & ~write_read_mbist & (bcast | sel_ok);
  assign ret     = tag_vld_q[DEPTH-1];

  always_comb begin
    ready_mbist = 1'b0;
    case (state_q)
      ST_IDLE: ready_mbist = 1'b1;
      ST_BUSY: ready_mbist = bcast | ~req_mbist | sel_hit;
      default: ready_mbist = 1'b0;
    endcase
  end

  always_comb begin
    req_d   = '0;
    wr_d    = '0;
    addr_d  = '0;
    wdata_d = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      if (accept && (bcast || memory_sel == SEL_WIDTH'(i))) begin
        req_d[i]                             = 1'b1;
        wr_d[i]                              = write_read_mbist;
        addr_d[i*ADDR_WIDTH +: ADDR_WIDTH]   = address_mbist;
        wdata_d[i*DATA_WIDTH +: DATA_WIDTH]  = wdata_mbist;
      end
    end
  end

  // Broadcast reads are tagged as channel 0, which is the channel returned.
  always_comb begin
    tag_vld_d    = {tag_vld_q[DEPTH-2:0], rd_push};
    tag_sel_d    = '0;
    tag_sel_d[0] = bcast ? '0 : memory_sel;
    for (int k = 1; k < DEPTH; k++) tag_sel_d[k] = tag_sel_q[k-1];
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ret;
    if (ret) begin
      for (int i = 0; i < NUM_MEM; i++) begin
        if (tag_sel_q[DEPTH-1] == SEL_WIDTH'(i)) rdata_d = rdata_mem[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    case ({rd_push, ret})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    sel_err_d = sel_err_q | (accept & ~bcast & ~sel_ok);
    if (accept && !bcast) cur_sel_d = memory_sel;
    case (state_q)
      ST_IDLE:  if (rd_push) state_d = ST_BUSY;
      ST_BUSY: begin
        if (cnt_d == '0)                           state_d = ST_IDLE;
        else if (req_mbist && !bcast && !sel_hit)  state_d = ST_DRAIN;
      end
      ST_DRAIN: if (cnt_d == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_sel_q <= '0;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      tag_sel_q <= '0;
      req_q     <= '0;
      wr_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= tag_vld_d;
      tag_sel_q <= tag_sel_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      sel_err_q <= sel_err_d;
    end
  end

`ifdef MBIST_BROADCAST_EN
  logic [DEPTH-1:0] tag_bc_q, tag_bc_d;
  logic             miscmp_q, miscmp_d;

  always_comb begin
    tag_bc_d = {tag_bc_q[DEPTH-2:0], rd_push & bcast};
    miscmp_d = 1'b0;
    if (ret && tag_bc_q[DEPTH-1]) begin
      for (int i = 1; i < NUM_MEM; i++) begin
        if (rdata_mem[i*DATA_WIDTH +: DATA_WIDTH] != rdata_mem[DATA_WIDTH-1:0]) miscmp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_bc_q <= '0;
      miscmp_q <= 1'b0;
    end else begin
      tag_bc_q <= tag_bc_d;
      miscmp_q <= miscmp_d;
    end
  end

  assign miscompare_mbist = miscmp_q;
`endif

  assign req_mem        = req_q;
  assign write_read_mem = wr_q;
  assign address_mem    = addr_q;
  assign wdata_mem      = wdata_q;
  assign rdata_mbist    = rdata_q;
  assign rvalid_mbist   = rvalid_q;
  assign sel_err        = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mbist_mem_router.sv
`default_nettype none
// Directed bench for mbist_mem_router: per-cycle vector table plus a reset-in-flight sequence.
module tb_mbist_mem_router;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int NM = 4;
  localparam int SW = 3;
  localparam int RL = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [SW-1:0]      memory_sel = '0;
  logic               req_mbist = 1'b0;
  logic               write_read_mbist = 1'b0;
  logic [AW-1:0]      address_mbist = '0;
  logic [DW-1:0]      wdata_mbist = '0;
  logic               ready_mbist;
  logic [DW-1:0]      rdata_mbist;
  logic               rvalid_mbist;
  logic               sel_err;
  logic [NM-1:0]      req_mem;
  logic [NM-1:0]      write_read_mem;
  logic [NM*AW-1:0]   address_mem;
  logic [NM*DW-1:0]   wdata_mem;
  logic [NM*DW-1:0]   rdata_mem;
`ifdef MBIST_BROADCAST_EN
  logic               broadcast_mbist = 1'b0;
  logic               miscompare_mbist;
`endif

  int checks = 0;
  int errors = 0;

  mbist_mem_router #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_MEM(NM), .SEL_WIDTH(SW), .RD_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MBIST_BROADCAST_EN
    .broadcast_mbist(broadcast_mbist),
    .miscompare_mbist(miscompare_mbist),
`endif
    .memory_sel(memory_sel),
    .req_mbist(req_mbist),
    .write_read_mbist(write_read_mbist),
    .address_mbist(address_mbist),
    .wdata_mbist(wdata_mbist),
    .ready_mbist(ready_mbist),
    .rdata_mbist(rdata_mbist),
    .rvalid_mbist(rvalid_mbist),
    .sel_err(sel_err),
    .req_mem(req_mem),
    .write_read_mem(write_read_mem),
    .address_mem(address_mem),
    .wdata_mem(wdata_mem),
    .rdata_mem(rdata_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd_val(input int ch, input logic [AW-1:0] a);
    return {16'(ch), 32'h0, a};
  endfunction

  // Latency-1 memories: data appears the cycle after a read strobe, garbage otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < NM; i++) begin
      if (req_mem[i] && !write_read_mem[i])
        rdata_mem[i*DW +: DW] <= rd_val(i, address_mem[i*AW +: AW]);
      else
        rdata_mem[i*DW +: DW] <= 64'hDEAD_BEEF_0000_0000 | 64'(i);
    end
  end

  typedef struct {
    logic          req;
    logic          wr;
    logic [SW-1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          e_ready;
    logic [NM-1:0] e_req;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_err;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic wr, input logic [SW-1:0] sel,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic e_ready, input logic [NM-1:0] e_req, input logic e_rv,
                              input logic [DW-1:0] e_rd, input logic e_err);
    vec_t v;
    v.req = req; v.wr = wr; v.sel = sel; v.addr = addr; v.wdata = wdata;
    v.e_ready = e_ready; v.e_req = e_req; v.e_rv = e_rv; v.e_rd = e_rd; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  localparam logic [DW-1:0] A5  = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [DW-1:0] R1  = 64'h0001_0000_0000_1234;
  localparam logic [DW-1:0] R0  = 64'h0000_0000_0000_0042;
  localparam logic [DW-1:0] R3  = 64'h0003_0000_0000_0077;
  localparam logic [DW-1:0] R20 = 64'h0002_0000_0000_0000;
  localparam logic [DW-1:0] R21 = 64'h0002_0000_0000_0001;
  localparam logic [DW-1:0] R22 = 64'h0002_0000_0000_0002;
  localparam logic [DW-1:0] R23 = 64'h0002_0000_0000_0003;

  initial begin
    vec_t v[27];
    logic          p_acc;
    int            p_sel;
    logic          p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wd;
    logic [NM*AW-1:0] e_addr;
    logic [NM*DW-1:0] e_wd;
    logic [NM-1:0]    e_wr;

    //        req wr sel addr      wdata  | rdy req_mem  rv rdata err
    v[0]  = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 0, 0,   0);
    v[1]  = mk(1, 1, 2, 16'h0010, A5,     1, 4'b0000, 0, 0,   0);
    v[2]  = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0100, 0, 0,   0);
    v[3]  = mk(1, 0, 1, 16'h1234, 0,      1, 4'b0000, 0, 0,   0);
    v[4]  = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0010, 0, 0,   0);
    v[5]  = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 0, 0,   0);
    v[6]  = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 1, R1,  0);
    v[7]  = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 0, R1,  0);
    v[8]  = mk(1, 0, 0, 16'h0042, 0,      1, 4'b0000, 0, R1,  0);
    v[9]  = mk(1, 0, 3, 16'h0077, 0,      0, 4'b0001, 0, R1,  0);
    v[10] = mk(1, 0, 3, 16'h0077, 0,      0, 4'b0000, 0, R1,  0);
    v[11] = mk(1, 0, 3, 16'h0077, 0,      1, 4'b0000, 1, R0,  0);
    v[12] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b1000, 0, R0,  0);
    v[13] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 0, R0,  0);
    v[14] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 1, R3,  0);
    v[15] = mk(1, 0, 2, 16'h0000, 0,      1, 4'b0000, 0, R3,  0);
    v[16] = mk(1, 0, 2, 16'h0001, 0,      1, 4'b0100, 0, R3,  0);
    v[17] = mk(1, 0, 2, 16'h0002, 0,      1, 4'b0100, 0, R3,  0);
    v[18] = mk(1, 0, 2, 16'h0003, 0,      1, 4'b0100, 1, R20, 0);
    v[19] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0100, 1, R21, 0);
    v[20] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 1, R22, 0);
    v[21] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 1, R23, 0);
    v[22] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 0, R23, 0);
    v[23] = mk(1, 1, 5, 16'h5555, 64'h1,  1, 4'b0000, 0, R23, 0);
    v[24] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0000, 0, R23, 1);
    v[25] = mk(1, 1, 1, 16'h0011, 64'h11, 1, 4'b0000, 0, R23, 1);
    v[26] = mk(0, 0, 0, 16'h0000, 0,      1, 4'b0010, 0, R23, 1);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset ready", 256'(ready_mbist), 256'(1));
    chk("reset req_mem", 256'(req_mem), 256'(0));
    chk("reset rvalid", 256'(rvalid_mbist), 256'(0));
    chk("reset sel_err", 256'(sel_err), 256'(0));
    chk("reset rdata", 256'(rdata_mbist), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    p_acc = 1'b0; p_sel = 0; p_wr = 1'b0; p_addr = '0; p_wd = '0;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      req_mbist = v[k].req; write_read_mbist = v[k].wr; memory_sel = v[k].sel;
      address_mbist = v[k].addr; wdata_mbist = v[k].wdata;
      #1;
      e_addr = '0; e_wd = '0; e_wr = '0;
      if (p_acc && p_sel < NM) begin
        e_addr[p_sel*AW +: AW] = p_addr;
        e_wd[p_sel*DW +: DW]   = p_wd;
        e_wr[p_sel]            = p_wr;
      end
      chk($sformatf("v%0d ready", k), 256'(ready_mbist), 256'(v[k].e_ready));
      chk($sformatf("v%0d req_mem", k), 256'(req_mem), 256'(v[k].e_req));
      chk($sformatf("v%0d write_read_mem", k), 256'(write_read_mem), 256'(e_wr));
      chk($sformatf("v%0d address_mem", k), 256'(address_mem), 256'(e_addr));
      chk($sformatf("v%0d wdata_mem", k), 256'(wdata_mem), 256'(e_wd));
      chk($sformatf("v%0d rvalid", k), 256'(rvalid_mbist), 256'(v[k].e_rv));
      chk($sformatf("v%0d rdata", k), 256'(rdata_mbist), 256'(v[k].e_rd));
      chk($sformatf("v%0d sel_err", k), 256'(sel_err), 256'(v[k].e_err));
      p_acc = v[k].req && v[k].e_ready;
      p_sel = int'(v[k].sel); p_wr = v[k].wr; p_addr = v[k].addr; p_wd = v[k].wdata;
    end

    // Reset while a read is in flight: tag must be dropped, sel_err cleared.
    @(negedge clk);
    req_mbist = 1'b1; write_read_mbist = 1'b0; memory_sel = 3'd1; address_mbist = 16'h0001;
    @(negedge clk);
    req_mbist = 1'b0;
    #1;
    chk("inflight req_mem", 256'(req_mem), 256'(4'b0010));
    rst_n = 1'b0;
    #1;
    chk("midrst req_mem", 256'(req_mem), 256'(0));
    chk("midrst address_mem", 256'(address_mem), 256'(0));
    chk("midrst sel_err", 256'(sel_err), 256'(0));
    chk("midrst rvalid", 256'(rvalid_mbist), 256'(0));
    chk("midrst rdata", 256'(rdata_mbist), 256'(0));
    chk("midrst ready", 256'(ready_mbist), 256'(1));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst%0d rvalid", k), 256'(rvalid_mbist), 256'(0));
      chk($sformatf("post-rst%0d req_mem", k), 256'(req_mem), 256'(0));
      chk($sformatf("post-rst%0d ready", k), 256'(ready_mbist), 256'(1));
      chk($sformatf("post-rst%0d sel_err", k), 256'(sel_err), 256'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
